// File: rtl/bcd_calc_core.sv
// Four-function decimal calculator core: debounced button events, sequential divider and
// double-dabble converter, multiplexed seven-segment output.
module bcd_calc_core #(
   parameter int DIGITS    = 4,
   parameter int SCAN_BITS = 18
) (
   input  logic              clock_100Mhz,
   input  logic              reset,
   input  logic [DIGITS-1:0] digit_btn,
   input  logic [3:0]        op_btn,
   input  logic              clear_btn,
   output logic              busy,
   output logic              done,
   output logic              negative,
   output logic              error,
   output logic [DIGITS-1:0] Anode_Activate,
   output logic [7:0]        LED_out
);

   localparam int RES_W = $clog2(10 ** DIGITS);
   localparam int HALF  = DIGITS / 2;
   localparam int NBTN  = DIGITS + 5;
   localparam int CNT_W = $clog2(RES_W);
   localparam int IDX_W = $clog2(DIGITS);
   localparam int BCD_W = DIGITS * 4;

   typedef enum logic [2:0] {S_ENTRY, S_CALC, S_DIV, S_CONV, S_SHOW} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'b0000_0011;
         4'd1:    seg7 = 8'b1001_1111;
         4'd2:    seg7 = 8'b0010_0101;
         4'd3:    seg7 = 8'b0000_1101;
         4'd4:    seg7 = 8'b1001_1001;
         4'd5:    seg7 = 8'b0100_1001;
         4'd6:    seg7 = 8'b0100_0001;
         4'd7:    seg7 = 8'b0001_1111;
         4'd8:    seg7 = 8'b0000_0001;
         4'd9:    seg7 = 8'b0000_1001;
         default: seg7 = 8'b1111_1111;
      endcase
   endfunction

   function automatic logic [3:0] inc_digit(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   function automatic logic [RES_W-1:0] bcd_to_bin(input logic [HALF*4-1:0] bcd);
      logic [RES_W-1:0] acc;
      acc = '0;
      for (int i = HALF - 1; i >= 0; i--)
         acc = RES_W'(acc * RES_W'(10)) + RES_W'(bcd[i*4 +: 4]);
      return acc;
   endfunction

   // One double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
   function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] bcd, input logic bit_in);
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int i = 0; i < DIGITS; i++)
         if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      return BCD_W'({adj, bit_in});
   endfunction

   logic [NBTN-1:0] btn_raw, sync_p0, sync_p1, sync_p2, evt_p3;
   assign btn_raw = {clear_btn, op_btn, digit_btn};

   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         sync_p2 <= '0;
         evt_p3  <= '0;
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
         evt_p3  <= sync_p1 & ~sync_p2;
      end
   end

   logic              ev_clr, ev_op, ev_dig;
   op_t               ev_kind;
   logic [DIGITS-1:0] dig_evt, dig_sel;
   assign dig_evt = evt_p3[DIGITS-1:0];
   assign dig_sel = dig_evt & (~dig_evt + DIGITS'(1));

   always_comb begin
      ev_clr  = evt_p3[NBTN-1];
      ev_op   = 1'b0;
      ev_kind = OP_ADD;
      ev_dig  = 1'b0;
      if (!ev_clr) begin
         if (evt_p3[DIGITS+3]) begin
            ev_op = 1'b1; ev_kind = OP_ADD;
         end else if (evt_p3[DIGITS+2]) begin
            ev_op = 1'b1; ev_kind = OP_SUB;
         end else if (evt_p3[DIGITS+1]) begin
            ev_op = 1'b1; ev_kind = OP_MUL;
         end else if (evt_p3[DIGITS]) begin
            ev_op = 1'b1; ev_kind = OP_DIV;
         end else begin
            ev_dig = |dig_evt;
         end
      end
   end

   state_t             state_q, state_d;
   op_t                op_q;
   logic [BCD_W-1:0]   entry_q, bcd_q, disp_q;
   logic [RES_W-1:0]   res_q, rem_q, a_bin, b_bin;
   logic [RES_W:0]     dvs_q, rem_sh;
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_pend_q, cnt_last;

   assign a_bin    = bcd_to_bin(entry_q[BCD_W-1 -: HALF*4]);
   assign b_bin    = bcd_to_bin(entry_q[HALF*4-1:0]);
   assign cnt_last = (cnt_q == CNT_W'(RES_W - 1));
   assign rem_sh   = {rem_q, res_q[RES_W-1]};

   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) state_q <= S_ENTRY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      case (state_q)
         S_ENTRY: if (ev_op) state_d = S_CALC;
         S_CALC: begin
            busy = 1'b1;
            if (op_q != OP_DIV)    state_d = S_CONV;
            else if (b_bin == '0)  state_d = S_SHOW;
            else                   state_d = S_DIV;
         end
         S_DIV: begin
            busy = 1'b1;
            if (cnt_last) state_d = S_CONV;
         end
         S_CONV: begin
            busy = 1'b1;
            if (cnt_last) state_d = S_SHOW;
         end
         S_SHOW: begin
            if (ev_op)                 state_d = S_CALC;
            else if (ev_clr || ev_dig) state_d = S_ENTRY;
         end
         default: state_d = S_ENTRY;
      endcase
   end

   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         op_q       <= OP_ADD;
         entry_q    <= '0;
         bcd_q      <= '0;
         disp_q     <= '0;
         res_q      <= '0;
         rem_q      <= '0;
         dvs_q      <= '0;
         cnt_q      <= '0;
         neg_pend_q <= 1'b0;
         negative   <= 1'b0;
         error      <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_ENTRY: begin
               if (ev_op) op_q <= ev_kind;
               else if (ev_dig)
                  for (int i = 0; i < DIGITS; i++)
                     if (dig_sel[i]) entry_q[i*4 +: 4] <= inc_digit(entry_q[i*4 +: 4]);
            end
            S_CALC: begin
               cnt_q      <= '0;
               bcd_q      <= '0;
               rem_q      <= '0;
               neg_pend_q <= 1'b0;
               case (op_q)
                  OP_ADD: res_q <= a_bin + b_bin;
                  OP_SUB: begin
                     res_q      <= (b_bin > a_bin) ? b_bin - a_bin : a_bin - b_bin;
                     neg_pend_q <= (b_bin > a_bin);
                  end
                  OP_MUL: res_q <= a_bin * b_bin;
                  default: begin
                     // Rounded divide: floor((2A+B)/(2B)) is A/B rounded half-up.
                     if (b_bin == '0) error <= 1'b1;
                     else begin
                        res_q <= (a_bin << 1) + b_bin;
                        dvs_q <= {b_bin, 1'b0};
                     end
                  end
               endcase
            end
            S_DIV: begin
               cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
               if (rem_sh >= dvs_q) begin
                  rem_q <= RES_W'(rem_sh - dvs_q);
                  res_q <= {res_q[RES_W-2:0], 1'b1};
               end else begin
                  rem_q <= rem_sh[RES_W-1:0];
                  res_q <= {res_q[RES_W-2:0], 1'b0};
               end
            end
            S_CONV: begin
               bcd_q <= dabble(bcd_q, res_q[RES_W-1]);
               res_q <= {res_q[RES_W-2:0], 1'b0};
               cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
               if (cnt_last) begin
                  disp_q   <= dabble(bcd_q, res_q[RES_W-1]);
                  negative <= neg_pend_q;
                  done     <= 1'b1;
               end
            end
            S_SHOW: begin
               if (ev_op) op_q <= ev_kind;
               if (ev_op || ev_clr || ev_dig) begin
                  negative <= 1'b0;
                  error    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   logic [SCAN_BITS-1:0] scan_cnt_q;
   logic [IDX_W-1:0]     scan_idx_q;

   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         scan_cnt_q <= '0;
         scan_idx_q <= IDX_W'(DIGITS - 1);
      end else begin
         scan_cnt_q <= scan_cnt_q + SCAN_BITS'(1);
         if (&scan_cnt_q)
            scan_idx_q <= (scan_idx_q == '0) ? IDX_W'(DIGITS - 1) : scan_idx_q - IDX_W'(1);
      end
   end

   logic [3:0] ent_dig, res_dig;
   logic       is_top, is_sep;

   assign Anode_Activate = ~(DIGITS'(1) << scan_idx_q);

   always_comb begin
      ent_dig = 4'd0;
      res_dig = 4'd0;
      LED_out = 8'b1111_1111;
      for (int i = 0; i < DIGITS; i++)
         if (scan_idx_q == IDX_W'(i)) begin
            ent_dig = entry_q[i*4 +: 4];
            res_dig = disp_q[i*4 +: 4];
         end
      is_top = (scan_idx_q == IDX_W'(DIGITS - 1));
      is_sep = (scan_idx_q == IDX_W'(HALF));
      if (state_q == S_SHOW) begin
         if (error)                  LED_out = is_top ? 8'b0110_0001 : 8'b1111_1111;
         else if (negative && is_top) LED_out = 8'b1111_1101;
         else                         LED_out = seg7(res_dig);
      end else begin
         LED_out = seg7(ent_dig);
         if (is_sep) LED_out[0] = 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_calc_core.sv
// Randomised self-checking bench for bcd_calc_core against an arithmetic reference model
// of the entry digits, results and display contents.
module tb_bcd_calc_core;

   localparam int DIGITS    = 4;
   localparam int SCAN_BITS = 2;

   logic              clock_100Mhz = 1'b0;
   logic              reset;
   logic [DIGITS-1:0] digit_btn;
   logic [3:0]        op_btn;
   logic              clear_btn;
   logic              busy, done, negative, error;
   logic [DIGITS-1:0] Anode_Activate;
   logic [7:0]        LED_out;

   bcd_calc_core #(.DIGITS(DIGITS), .SCAN_BITS(SCAN_BITS)) dut (
      .clock_100Mhz   (clock_100Mhz),
      .reset          (reset),
      .digit_btn      (digit_btn),
      .op_btn         (op_btn),
      .clear_btn      (clear_btn),
      .busy           (busy),
      .done           (done),
      .negative       (negative),
      .error          (error),
      .Anode_Activate (Anode_Activate),
      .LED_out        (LED_out)
   );

   always #5 clock_100Mhz = ~clock_100Mhz;

   int n_tests  = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int ent[DIGITS];
   bit in_show;

   logic [7:0] seg_tab [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
                                8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
                                8'b00000001, 8'b00001001};

   always @(negedge clock_100Mhz) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock_100Mhz);
   endtask

   task automatic press_digit(input int i);
      digit_btn[i] = 1'b1;
      cyc(5);
      digit_btn[i] = 1'b0;
      cyc(4);
      if (in_show) in_show = 1'b0;
      else         ent[i] = (ent[i] + 1) % 10;
   endtask

   task automatic press_clear();
      clear_btn = 1'b1;
      cyc(5);
      clear_btn = 1'b0;
      cyc(4);
      in_show = 1'b0;
   endtask

   task automatic set_entry(input int a, input int b);
      int tgt[DIGITS];
      if (in_show) press_clear();
      tgt[3] = a / 10; tgt[2] = a % 10; tgt[1] = b / 10; tgt[0] = b % 10;
      for (int i = 0; i < DIGITS; i++)
         repeat ((tgt[i] - ent[i] + 10) % 10) press_digit(i);
   endtask

   function automatic logic [31:0] exp_entry();
      logic [31:0] d;
      logic [7:0]  c;
      for (int i = 0; i < DIGITS; i++) begin
         c = seg_tab[ent[i]];
         if (i == DIGITS / 2) c[0] = 1'b0;
         d[i*8 +: 8] = c;
      end
      return d;
   endfunction

   function automatic logic [31:0] exp_result(input int val, input bit neg, input bit err);
      logic [31:0] d;
      int v;
      v = val;
      for (int i = 0; i < DIGITS; i++) begin
         d[i*8 +: 8] = err ? 8'b11111111 : seg_tab[v % 10];
         v = v / 10;
      end
      if (err)      d[31:24] = 8'b01100001;
      else if (neg) d[31:24] = 8'b11111101;
      return d;
   endfunction

   task automatic read_disp(output logic [31:0] d);
      d = '0;
      repeat (4 * DIGITS * (1 << SCAN_BITS) / DIGITS + 8) begin
         @(negedge clock_100Mhz);
         for (int i = 0; i < DIGITS; i++)
            if (Anode_Activate == ~(4'b0001 << i)) d[i*8 +: 8] = LED_out;
      end
   endtask

   // k selects op_btn[k]: 3 add, 2 sub, 1 mul, 0 div.
   task automatic do_op(input int k, input bit dig_with, input bit dig_during, input int hold);
      int a, b, val, lat, d0, rises, exp_lat;
      bit neg, err, prev;
      logic [31:0] d;
      a = ent[3] * 10 + ent[2];
      b = ent[1] * 10 + ent[0];
      val = 0; neg = 1'b0; err = 1'b0;
      case (k)
         3: val = a + b;
         2: begin val = (a > b) ? a - b : b - a; neg = (b > a); end
         1: val = a * b;
         default: if (b == 0) err = 1'b1;
                  else val = int'($floor(real'(a) / real'(b) + 0.5));
      endcase
      exp_lat = (k == 0) ? (err ? 0 : 29) : 15;

      op_btn[k] = 1'b1;
      if (dig_with) digit_btn[0] = 1'b1;
      lat = 0;
      while (busy !== 1'b1 && lat < 12) begin cyc(1); lat++; end
      chk($sformatf("busy_rise_op%0d", k), busy, 1);
      d0 = done_cnt;
      if (exp_lat > 0) begin
         lat = 0;
         while (done !== 1'b1 && lat < 80) begin
            cyc(1);
            lat++;
            if (dig_during && lat == 2) digit_btn[1] = 1'b1;
         end
         chk($sformatf("latency_op%0d", k), lat, exp_lat);
         chk("busy_low_at_done", busy, 0);
      end else begin
         cyc(40);
      end
      prev = busy; rises = 0;
      repeat (hold) begin
         cyc(1);
         if (busy && !prev) rises++;
         prev = busy;
      end
      if (hold > 0) chk("held_op_fires_once", rises, 0);
      op_btn    = '0;
      digit_btn = '0;
      cyc(4);
      in_show = 1'b1;
      chk($sformatf("done_pulses_op%0d", k), done_cnt - d0, err ? 0 : 1);
      chk("negative", negative, neg);
      chk("error", error, err);
      read_disp(d);
      chk($sformatf("result_%0d_op%0d_%0d", a, k, b), d, exp_result(val, neg, err));
   endtask

   initial begin
      #800000;
      $display("FAIL timeout: run still active, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      int a, b, k, d0, lat;
      reset = 1'b0; digit_btn = '0; op_btn = '0; clear_btn = 1'b0;
      in_show = 1'b0;
      for (int i = 0; i < DIGITS; i++) ent[i] = 0;
      cyc(3);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_negative", negative, 0);
      chk("rst_error", error, 0);
      chk("rst_anode", Anode_Activate, 4'b0111);
      chk("rst_led", LED_out, 8'b00000011);
      reset = 1'b1;
      cyc(2);
      read_disp(d);
      chk("rst_entry", d, exp_entry());

      repeat (13) press_digit(0);
      read_disp(d);
      chk("digit_wrap", d, exp_entry());

      set_entry(12, 34);
      do_op(3, 1'b0, 1'b0, 0);
      do_op(2, 1'b0, 1'b0, 0);
      do_op(1, 1'b0, 1'b0, 0);

      press_clear();
      chk("clear_negative", negative, 0);
      chk("clear_error", error, 0);
      read_disp(d);
      chk("clear_entry", d, exp_entry());
      press_digit(0);
      read_disp(d);
      chk("entry_after_clear", d, exp_entry());

      set_entry(75, 4);
      do_op(0, 1'b0, 1'b0, 0);
      set_entry(25, 2);
      do_op(0, 1'b0, 1'b0, 0);
      set_entry(25, 0);
      do_op(0, 1'b0, 1'b0, 0);

      set_entry(12, 34);
      do_op(3, 1'b1, 1'b0, 0);
      press_clear();
      read_disp(d);
      chk("arb_digit_discarded", d, exp_entry());
      do_op(1, 1'b0, 1'b1, 40);
      press_clear();
      read_disp(d);
      chk("busy_digit_ignored", d, exp_entry());

      for (int r = 0; r < 8; r++) begin
         a = $urandom_range(0, 99);
         b = $urandom_range(0, 99);
         k = $urandom_range(0, 3);
         if (k == 0 && $urandom_range(0, 3) == 0) b = 0;
         set_entry(a, b);
         do_op(k, 1'b0, 1'b0, 0);
      end

      set_entry(75, 4);
      op_btn[0] = 1'b1;
      lat = 0;
      while (busy !== 1'b1 && lat < 12) begin cyc(1); lat++; end
      chk("mid_div_busy", busy, 1);
      d0 = done_cnt;
      cyc(11);
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_anode", Anode_Activate, 4'b0111);
      chk("mid_rst_led", LED_out, 8'b00000011);
      cyc(2);
      op_btn = '0;
      reset  = 1'b1;
      for (int i = 0; i < DIGITS; i++) ent[i] = 0;
      in_show = 1'b0;
      cyc(50);
      chk("mid_rst_no_done", done_cnt - d0, 0);
      chk("mid_rst_busy_after", busy, 0);
      read_disp(d);
      chk("mid_rst_entry", d, exp_entry());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_calc_core.md
# bcd_calc_core

Parametrised successor to the board-level four-digit calculator. It performs multiplexed seven-segment entry of two DIGITS/2-digit decimal operands and then add, subtract, multiply or rounded divide on the pair. Every button is synchronised and reduced to a single edge event. Division and binary-to-BCD conversion run as sequential multi-cycle engines, and the block reports busy, done, sign and error status. It sits between the board buttons and the anode/segment pins.

## Interface

Parameters:
- DIGITS, 4: display digits; even, 2..8. Operand A = digits DIGITS-1..DIGITS/2, operand B = digits DIGITS/2-1..0.
- SCAN_BITS, 18: a digit is held for 2^SCAN_BITS cycles.
- RES_W (derived): ceil(log2(10^DIGITS)); 14 for DIGITS=4.

Ports:
- clock_100Mhz  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- digit_btn  in  DIGITS  level; bit i increments decimal digit i (weight 10^i).
- op_btn  in  4  level; [3]=add, [2]=sub, [1]=mul, [0]=div.
- clear_btn  in  1  level; return from result to entry view.
- busy  out  1  high while in CALC/DIV/CONV.
- done  out  1  one-cycle pulse when the result is loaded for display.
- negative  out  1  the shown result is negative.
- error  out  1  the last divide had B=0.
- Anode_Activate  out  DIGITS  active-low; bit i enables digit i.
- LED_out  out  8  active-low; [7:1]=a..g, [0]=dp.

## Operation

- **Input conditioning**
  - Each button passes through a 2-flop synchroniser plus a rising-edge detector.
  - Holding a button yields exactly one event.
- **Event arbitration, one per cycle**
  - Priority: clear > add > sub > mul > div > lowest-index digit.
  - Lower-priority edges in the same cycle are discarded.
- **FSM states**
  - ENTRY
    - Digit event: increments that digit, 9 wraps to 0 with no carry.
    - Op event: goes to CALC.
    - Clear: no effect.
  - CALC (1 cycle)
    - Convert A and B to binary.
    - add: R=A+B. sub: R=|A-B|, negative=(B>A). mul: R=A*B. In all three cases go to CONV.
    - div with B=0: error=1, go to SHOW.
    - div otherwise: load dividend 2A+B and divisor 2B, go to DIV.
  - DIV (RES_W cycles)
    - Restoring divider, 1 quotient bit per cycle.
    - R = floor((2A+B)/(2B)), i.e. A/B rounded half-up. Then go to CONV.
  - CONV (RES_W cycles)
    - Shift-add-3 (double-dabble) of R into DIGITS BCD digits.
    - On the last cycle, load the display register, pulse done, go to SHOW.
  - SHOW
    - Op event recomputes from the unchanged entry operands: clear negative/error, go to CALC.
    - Digit or clear event returns to ENTRY with the entry unchanged; the press is consumed and not applied. negative and error clear.
- **Event handling while busy**
  - All events are ignored.
  - Edge detectors keep tracking, so a button held through busy does not fire afterwards.
- **Width rules**
  - Entry values never overflow: add ≤ 2·(10^(DIGITS/2)-1), mul ≤ (10^(DIGITS/2)-1)^2, div ≤ 2A+B.
  - No modulo is applied.
- **Display**
  - Scan counter advances the digit every 2^SCAN_BITS cycles, visiting DIGITS-1 down to 0, then wrapping.
  - ENTRY: entry digits are shown, with dp lit on digit DIGITS/2 as the operand separator.
  - SHOW: result digits are shown, no dp.
  - Negative: digit DIGITS-1 shows "-" (11111101); the magnitude never reaches that digit.
  - Error: digit DIGITS-1 shows "E" (01100001) and all other digits are blank (11111111).
  - Digit codes 0–9: 00000011, 10011111, 00100101, 00001101, 10011001, 01001001, 01000001, 00011111, 00000001, 00001001. Clear bit 0 for dp.

## Timing

- **Reset (reset=0)**, effective immediately and asynchronously:
  - State ENTRY, entry digits 0, R=0.
  - busy=0, done=0, negative=0, error=0.
  - Scan at digit DIGITS-1: Anode_Activate = all ones except bit DIGITS-1 (0111 for DIGITS=4); LED_out=00000011.
  - Synchroniser flops cleared.
- **Reset mid-operation**: reset in DIV or CONV aborts the operation and restores all reset values. No done is issued.
- **Event timing**: an event occurs 3 clocks after the button input rises (2 synchroniser flops, 1 edge detector). State changes on the next edge.
- **Latency from op event to done** (busy rises 1 cycle after the event, falls with done):
  - add/sub/mul: 1+RES_W cycles (15 for DIGITS=4).
  - div: 1+2·RES_W cycles (29).
  - div by zero: 1 cycle, no done pulse, error=1.
- **Output update**: the display register and status update on the cycle done pulses. LED_out follows the scan combinationally.

## Test plan

- **Digit wrap**: reset, 13 presses on digit_btn[0] → digit 0 = 3; digits 1..3 = 0; dp on digit 2.
- **Add/sub/mul**: entry A=12, B=34.
  - add → done at +15, shows 0046.
  - SHOW, sub → 22 with negative=1 and "-" on digit 3.
  - SHOW, mul → 0408.
- **Divide rounding and divide by zero**:
  - A=75, B=04 → 19, done at +29.
  - A=25, B=02 → 13.
  - A=25, B=00 → error=1, "E" on digit 3, no done pulse.
- **Clear from SHOW**: after add on 12|34, clear → ENTRY shows 12.34. negative=0 and error=0. The next digit_btn[0] press gives 12.35.
- **Arbitration and busy**:
  - op_btn[3] and digit_btn[0] rise together → add runs, digit unchanged.
  - digit_btn[1] pressed during busy → ignored.
  - A held op_btn fires only once.
- **Reset mid-divide**: reset=0 at cycle 10 of DIV → all reset values, entry 0000, no done pulse.
